instr_fetch_unit: RTL and testbench

// - IF-stage requester for the sync-address instruction memory: owns the PC and drives en/addr.
// - Captures instr_d one cycle after issue and buffers it in a small FIFO toward decode.
// - Decode pulls instructions with a valid/ready handshake.
// - Handles decode backpressure and branch/jump redirects; wrong-path fetches are squashed.

---
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: redirect request, sync instruction-memory port and decode-side valid/ready.
interface instr_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_en, imem_addr, out_valid, out_pc, out_instr, out_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_en, imem_addr, out_valid, out_pc, out_instr, out_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches from a sync-read instruction memory and buffers words toward decode.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef FETCH_MISALIGN_TRAP_EN
        logic        fault;
`endif
    } entry_t;

    logic [31:0]      pc_q;
    logic             inflight_q;
    logic [31:0]      inflight_pc_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    entry_t           fifo_q [FIFO_DEPTH];

    logic [31:0]      tgt_c;
    logic             trap_c;
    logic             stall_c;
    logic             fault_pend_c;
    logic [31:0]      occ_c;
    logic             issue_c;
    logic             fetch_c;
    logic             pop_c;
    logic             push_c;
    entry_t           head_c;
    entry_t           push_entry_c;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halt_q;
    logic fault_pend_q;

    assign tgt_c        = bus.redirect_pc;
    assign trap_c       = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    // An aligned redirect releases the halt in the same cycle so its target issues without a bubble.
    assign stall_c      = halt_q && !bus.redirect_valid;
    assign fault_pend_c = fault_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q       <= 1'b0;
            fault_pend_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            halt_q       <= trap_c;
            fault_pend_q <= trap_c;
        end else begin
            fault_pend_q <= 1'b0;
        end
    end
`else
    logic unused_align_c;

    assign unused_align_c = ^bus.redirect_pc[1:0];
    assign tgt_c          = {bus.redirect_pc[31:2], 2'b00};
    assign trap_c         = 1'b0;
    assign stall_c        = 1'b0;
    assign fault_pend_c   = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Issue only when the returning word is guaranteed a FIFO slot.
    assign occ_c    = 32'(count_q) + 32'(inflight_q) - 32'(pop_c);
    assign issue_c  = !rst && !stall_c && (occ_c < FIFO_DEPTH);
    assign fetch_c  = issue_c && !trap_c;

    assign bus.imem_en   = fetch_c;
    assign bus.imem_addr = bus.redirect_valid ? tgt_c : pc_q;

    assign head_c        = fifo_q[rd_ptr_q];
    assign bus.out_valid = !rst && (count_q != '0);
    assign bus.out_pc    = head_c.pc;
    assign bus.out_instr = head_c.instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.out_fault = bus.out_valid && head_c.fault;
`else
    assign bus.out_fault = 1'b0;
`endif

    assign pop_c  = bus.out_valid && bus.out_ready;
    assign push_c = !bus.redirect_valid && (inflight_q || fault_pend_c);

    always_comb begin
        push_entry_c       = '0;
        push_entry_c.pc    = inflight_pc_q;
        push_entry_c.instr = bus.imem_rdata;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (fault_pend_c) begin
            push_entry_c.instr = NOP;
            push_entry_c.fault = 1'b1;
        end
`endif
    end

    // PC, inflight tracking and FIFO pointers; a redirect flushes the buffer and wrong-path return.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            // A redirect that cannot issue this cycle must still fetch its own target next.
            pc_q          <= fetch_c ? bus.imem_addr + 32'd4 : bus.imem_addr;
            inflight_q    <= fetch_c;
            inflight_pc_q <= bus.imem_addr;
            if (bus.redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_c) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (pop_c) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            fifo_q[wr_ptr_q] <= push_entry_c;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle vectors, directed redirect/wrap/trap sequences,
// and a randomized run checked against a stream-level model of the decode-visible instruction order.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [256];

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a < 32'h400) return rom[a[9:2]];
        return NOP;
    endfunction

    // Sync-read memory: data for the enabled address appears the following cycle and then holds.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= word(bus.imem_addr);
    end

    int checks = 0;
    int errors = 0;

    // Stream model: after reset or a redirect to T, decode sees T, T+4, ... with the memory word for each.
    logic [31:0] exp_pc;
    logic [31:0] trap_pc;
    bit          trap_pend;
    bit          halted;
    bit          prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        prev_fault;
    int          pops;
    logic [31:0] popped[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rs, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic pop;
        @(negedge clk);
        rst                = rs;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        #1;
        if (rs) begin
            check("rst_imem_en", 32'(bus.imem_en), 32'd0);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_out_fault", 32'(bus.out_fault), 32'd0);
            exp_pc    = RESET_PC;
            trap_pend = 1'b0;
            halted    = 1'b0;
            prev_hold = 1'b0;
            return;
        end
        if (prev_hold) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_pc", bus.out_pc, prev_pc);
            check("hold_instr", bus.out_instr, prev_instr);
            check("hold_fault", 32'(bus.out_fault), 32'(prev_fault));
        end
        pop = bus.out_valid && rdy;
        if (pop) begin
            pops++;
            popped.push_back(bus.out_pc);
            if (trap_pend) begin
                check("trap_pc", bus.out_pc, trap_pc);
                check("trap_instr", bus.out_instr, NOP);
                check("trap_fault", 32'(bus.out_fault), 32'd1);
                trap_pend = 1'b0;
                halted    = 1'b1;
            end else if (halted) begin
                check("pop_while_halted", bus.out_pc, 32'hxxxx_xxxx);
            end else begin
                check("stream_pc", bus.out_pc, exp_pc);
                check("stream_instr", bus.out_instr, word(exp_pc));
                check("stream_fault", 32'(bus.out_fault), 32'd0);
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (rv) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) begin
                trap_pend = 1'b1;
                trap_pc   = rpc;
            end else begin
                trap_pend = 1'b0;
                exp_pc    = rpc;
            end
            halted = 1'b0;
`else
            exp_pc = {rpc[31:2], 2'b00};
`endif
        end
        prev_hold  = bus.out_valid && !rdy && !rv;
        prev_pc    = bus.out_pc;
        prev_instr = bus.out_instr;
        prev_fault = bus.out_fault;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, rdy);
    endtask

    task automatic expect_seq(input string name, input logic [31:0] first, input int n);
        check({name, "_count"}, 32'(popped.size() >= n), 32'd1);
        for (int k = 0; k < n && k < popped.size(); k++)
            check($sformatf("%s_pc%0d", name, k), popped[k], first + 32'(4 * k));
    endtask

    typedef struct {
        logic        ready;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs [12];
    logic        r_rs, r_rv, r_rdy;
    logic [31:0] r_pc;
    int          pops_start;

    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        foreach (rom[i]) rom[i] = $urandom;

        // Reset release then backpressure from cycle 3 for five cycles.
        vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h04};
        vecs[5]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h04};
        vecs[6]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h04};
        vecs[7]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h04};
        vecs[8]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[9]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[10] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[11] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};

        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'h0, vecs[i].ready);
            check($sformatf("vec%0d_en", i), 32'(bus.imem_en), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en)
                check($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_instr", i), bus.out_instr, word(vecs[i].exp_pc));
            end
        end

        // Redirect coinciding with a pop: old head consumed, target issued with no bubble.
        step(1'b0, 1'b1, 32'h40, 1'b1);
        check("redir_en", 32'(bus.imem_en), 32'd1);
        check("redir_addr", bus.imem_addr, 32'h40);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_flush_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_first_valid", 32'(bus.out_valid), 32'd1);
        check("redir_first_pc", bus.out_pc, 32'h40);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_second_pc", bus.out_pc, 32'h44);

        // Redirect while the buffer is full and decode is stalled.
        run(3, 1'b0);
        check("full_en", 32'(bus.imem_en), 32'd0);
        check("full_valid", 32'(bus.out_valid), 32'd1);
        step(1'b0, 1'b1, 32'h80, 1'b0);
        popped.delete();
        run(6, 1'b1);
        expect_seq("bp_redir", 32'h80, 2);

        // PC wrap through the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        popped.delete();
        run(6, 1'b1);
        expect_seq("wrap", 32'hFFFF_FFF8, 3);

        // Reset in the middle of a stalled, full buffer.
        run(3, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        popped.delete();
        run(6, 1'b1);
        expect_seq("post_rst", RESET_PC, 3);

        // Misaligned redirect target.
        step(1'b0, 1'b1, 32'h102, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_no_issue", 32'(bus.imem_en), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("trap_gap_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("trap_entry_valid", 32'(bus.out_valid), 32'd1);
        check("trap_entry_fault", 32'(bus.out_fault), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            check($sformatf("halt%0d_en", k), 32'(bus.imem_en), 32'd0);
            check($sformatf("halt%0d_valid", k), 32'(bus.out_valid), 32'd0);
        end
        step(1'b0, 1'b1, 32'h200, 1'b1);
        check("resume_en", 32'(bus.imem_en), 32'd1);
        check("resume_addr", bus.imem_addr, 32'h200);
        popped.delete();
        run(4, 1'b1);
        expect_seq("resume", 32'h200, 2);
`else
        check("align_en", 32'(bus.imem_en), 32'd1);
        check("align_addr", bus.imem_addr, 32'h100);
        popped.delete();
        run(4, 1'b1);
        expect_seq("align", 32'h100, 2);
`endif

        // Randomized traffic against the stream model.
        pops_start = pops;
        for (int i = 0; i < 600; i++) begin
            r_rs  = ($urandom_range(0, 199) == 0);
            r_rv  = ($urandom_range(0, 11) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                r_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                r_pc = 32'($urandom_range(0, 32'h3FF));
            if ($urandom_range(0, 3) != 0) r_pc = r_pc & 32'hFFFF_FFFC;
            step(r_rs, r_rv, r_pc, r_rdy);
        end
        check("random_progress", 32'((pops - pops_start) > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
